// File: rtl/mips_regs_pkg.sv
// mips_regs_pkg
//   Shared constants for the dual-write-port MIPS register file:
//   default data/address widths and the clear-FSM state encoding.
package mips_regs_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    // Clear-engine state encoding
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/mips_regs_read_mux.sv
// mips_regs_read_mux
//   Per-port read select for the register file, in priority order:
//   clearing -> 0, hardwired zero register -> 0, port-2 bypass,
//   port-1 bypass, stored entry.
// Ports:
//   i_in_clear  file is being scrubbed; read returns 0
//   i_addr      read address
//   i_mem_data  stored entry at i_addr
//   i_commit_k  port-k write will commit at the coming edge
//   i_waddr_k   port-k write address
//   i_wdata_k   port-k write data
//   o_data      selected read data
module mips_regs_read_mux
    import mips_regs_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  i_in_clear,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_commit_1,
    input  logic [ADDR_WIDTH-1:0] i_waddr_1,
    input  logic [DATA_WIDTH-1:0] i_wdata_1,
    input  logic                  i_commit_2,
    input  logic [ADDR_WIDTH-1:0] i_waddr_2,
    input  logic [DATA_WIDTH-1:0] i_wdata_2,
    output logic [DATA_WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_mem_data;
        if (i_in_clear) begin
            o_data = '0;
        end else if ((ZERO_REG != 0) && (i_addr == '0)) begin
            o_data = '0;
        end else if ((BYPASS != 0) && i_commit_2 && (i_waddr_2 == i_addr)) begin
            // Port 2 is the younger instruction, so its data wins
            o_data = i_wdata_2;
        end else if ((BYPASS != 0) && i_commit_1 && (i_waddr_1 == i_addr)) begin
            o_data = i_wdata_1;
        end
    end

endmodule

// File: rtl/mips_registers_param.sv
// mips_registers_param
//   Parametrised dual-write / dual-read register file for the dual-issue
//   datapath. Two combinational read ports with optional write bypass,
//   two synchronous write ports (port 2 has priority), optional
//   hardwired-zero entry 0, and a sequential scrub engine that clears
//   every entry after reset or on clear_req, gating reads/writes until
//   ready is high.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   clear_req                   request full scrub (honoured when ready)
//   signal_reg_write_k          write enable, port k (k=1,2)
//   write_reg_k / write_data_k  write address / data, port k
//   read_reg_k / read_data_k    read address / combinational read data
//   ready                       file valid; writes accepted
module mips_registers_param
    import mips_regs_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    input  logic                  signal_reg_write_1,
    input  logic [ADDR_WIDTH-1:0] write_reg_1,
    input  logic [DATA_WIDTH-1:0] write_data_1,
    input  logic                  signal_reg_write_2,
    input  logic [ADDR_WIDTH-1:0] write_reg_2,
    input  logic [DATA_WIDTH-1:0] write_data_2,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic                  ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_clear_ptr;
    logic                  r_ready;

    logic                  w_in_clear;
    logic                  w_commit_1;
    logic                  w_commit_2;
    logic [DATA_WIDTH-1:0] w_mem_rd_1;
    logic [DATA_WIDTH-1:0] w_mem_rd_2;

    assign w_in_clear = (r_state == ST_CLEAR);

    // A write commits only in READY without a concurrent scrub request and
    // when it does not target a hardwired-zero entry 0. The same qualifier
    // gates bypass so reads never forward data that will be dropped.
    assign w_commit_1 = !w_in_clear && !clear_req && signal_reg_write_1 &&
                        !((ZERO_REG != 0) && (write_reg_1 == '0));
    assign w_commit_2 = !w_in_clear && !clear_req && signal_reg_write_2 &&
                        !((ZERO_REG != 0) && (write_reg_2 == '0));

    assign w_mem_rd_1 = r_mem[read_reg_1];
    assign w_mem_rd_2 = r_mem[read_reg_2];
    assign ready      = r_ready;

    // Clear-engine FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_CLEAR;
            r_clear_ptr <= '0;
            r_ready     <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_clear_ptr <= r_clear_ptr + 1'b1;
            if (r_clear_ptr == '1) begin
                r_state     <= ST_READY;
                r_ready     <= 1'b1;
                r_clear_ptr <= '0;
            end
        end else if (clear_req) begin
            r_state     <= ST_CLEAR;
            r_clear_ptr <= '0;
            r_ready     <= 1'b0;
        end
    end

    // Storage: scrub writes in CLEAR, port writes in READY. Port 2 is
    // assigned last so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_in_clear) begin
                r_mem[r_clear_ptr] <= '0;
            end else begin
                if (w_commit_1) begin
                    r_mem[write_reg_1] <= write_data_1;
                end
                if (w_commit_2) begin
                    r_mem[write_reg_2] <= write_data_2;
                end
            end
        end
    end

    mips_regs_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_read_mux_1 (
        .i_in_clear (w_in_clear),
        .i_addr     (read_reg_1),
        .i_mem_data (w_mem_rd_1),
        .i_commit_1 (w_commit_1),
        .i_waddr_1  (write_reg_1),
        .i_wdata_1  (write_data_1),
        .i_commit_2 (w_commit_2),
        .i_waddr_2  (write_reg_2),
        .i_wdata_2  (write_data_2),
        .o_data     (read_data_1)
    );

    mips_regs_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_read_mux_2 (
        .i_in_clear (w_in_clear),
        .i_addr     (read_reg_2),
        .i_mem_data (w_mem_rd_2),
        .i_commit_1 (w_commit_1),
        .i_waddr_1  (write_reg_1),
        .i_wdata_1  (write_data_1),
        .i_commit_2 (w_commit_2),
        .i_waddr_2  (write_reg_2),
        .i_wdata_2  (write_data_2),
        .o_data     (read_data_2)
    );

endmodule

// File: tb/tb_mips_registers_param.sv
// tb_mips_registers_param
//   Drives two register-file instances with shared stimulus:
//   dut_a uses ZERO_REG=1, BYPASS=1; dut_b uses ZERO_REG=0, BYPASS=0.
module tb_mips_registers_param;

    logic        clk;
    logic        reset;
    logic        clear_req;
    logic        we1, we2;
    logic [4:0]  wr1, wr2, rr1, rr2;
    logic [31:0] wd1, wd2;
    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_ready, b_ready;

    int checks;
    int failures;

    mips_registers_param #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .ZERO_REG   (1),
        .BYPASS     (1)
    ) dut_a (
        .clk                (clk),
        .reset              (reset),
        .clear_req          (clear_req),
        .signal_reg_write_1 (we1),
        .write_reg_1        (wr1),
        .write_data_1       (wd1),
        .signal_reg_write_2 (we2),
        .write_reg_2        (wr2),
        .write_data_2       (wd2),
        .read_reg_1         (rr1),
        .read_reg_2         (rr2),
        .read_data_1        (a_rd1),
        .read_data_2        (a_rd2),
        .ready              (a_ready)
    );

    mips_registers_param #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .ZERO_REG   (0),
        .BYPASS     (0)
    ) dut_b (
        .clk                (clk),
        .reset              (reset),
        .clear_req          (clear_req),
        .signal_reg_write_1 (we1),
        .write_reg_1        (wr1),
        .write_data_1       (wd1),
        .signal_reg_write_2 (we2),
        .write_reg_2        (wr2),
        .write_data_2       (wd2),
        .read_reg_1         (rr1),
        .read_reg_2         (rr2),
        .read_data_1        (b_rd1),
        .read_data_2        (b_rd2),
        .ready              (b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we1;
        logic [4:0]  wr1;
        logic [31:0] wd1;
        logic        we2;
        logic [4:0]  wr2;
        logic [31:0] wd2;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] exp_a1;
        logic [31:0] exp_a2;
        logic [31:0] exp_b1;
        logic [31:0] exp_b2;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        clear_req = 1'b0;
        we1 = 1'b0; wr1 = '0; wd1 = '0;
        we2 = 1'b0; wr2 = '0; wd2 = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        rr1      = '0;
        rr2      = '0;
        idle();

        //                we1 wr1  wd1           we2 wr2  wd2           rr1 rr2  a1            a2            b1            b2
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd3,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd9,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 5'd9,  32'h11111111, 1'b1, 5'd9,  32'h22222222, 5'd9,  5'd5,  32'h22222222, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  32'h22222222, 32'h0,        32'h22222222, 32'h0};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd9,  32'h0,        32'h22222222, 32'h0,        32'h22222222};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[6]  = '{1'b1, 5'd12, 32'hA5A5A5A5, 1'b1, 5'd13, 32'h0F0F0F0F, 5'd13, 5'd12, 32'h0F0F0F0F, 32'hA5A5A5A5, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  32'h0,        5'd12, 5'd13, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hA5A5A5A5, 32'h0F0F0F0F};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 32'h12345678, 32'h0,        32'h12345678, 32'h0};
        vecs[9]  = '{1'b1, 5'd31, 32'h00000001, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF};

        // Reset held two edges
        tick();
        tick();
        chk("reset_ready_a", {31'd0, a_ready}, 32'd0);
        chk("reset_ready_b", {31'd0, b_ready}, 32'd0);

        // Release reset with a port-1 write to reg 3 pending throughout the scrub
        reset = 1'b0;
        we1 = 1'b1; wr1 = 5'd3; wd1 = 32'h33333333;
        rr1 = 5'd3; rr2 = 5'd3;
        #1;
        chk("clear_read_a1", a_rd1, 32'h0);
        chk("clear_read_b2", b_rd2, 32'h0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k < 32) begin
                chk($sformatf("scrub_ready_a_e%0d", k), {31'd0, a_ready}, 32'd0);
                chk($sformatf("scrub_ready_b_e%0d", k), {31'd0, b_ready}, 32'd0);
                chk($sformatf("scrub_rd_a1_e%0d", k), a_rd1, 32'h0);
                chk($sformatf("scrub_rd_b1_e%0d", k), b_rd1, 32'h0);
            end else begin
                chk("scrub_done_ready_a", {31'd0, a_ready}, 32'd1);
                chk("scrub_done_ready_b", {31'd0, b_ready}, 32'd1);
            end
            if (k == 31) idle();
        end

        // Every entry reads zero after the scrub, including reg 3
        for (int unsigned r = 0; r < 32; r++) begin
            rr1 = 5'(r);
            rr2 = 5'(31 - r);
            #1;
            chk($sformatf("post_scrub_a_r%0d", r), a_rd1, 32'h0);
            chk($sformatf("post_scrub_b_r%0d", r), b_rd2, 32'h0);
        end

        // Table-driven write/read vectors; reads sampled before the write edge
        for (int i = 0; i < 11; i++) begin
            we1 = vecs[i].we1; wr1 = vecs[i].wr1; wd1 = vecs[i].wd1;
            we2 = vecs[i].we2; wr2 = vecs[i].wr2; wd2 = vecs[i].wd2;
            rr1 = vecs[i].rr1; rr2 = vecs[i].rr2;
            #1;
            chk($sformatf("vec%0d_a_rd1", i), a_rd1, vecs[i].exp_a1);
            chk($sformatf("vec%0d_a_rd2", i), a_rd2, vecs[i].exp_a2);
            chk($sformatf("vec%0d_b_rd1", i), b_rd1, vecs[i].exp_b1);
            chk($sformatf("vec%0d_b_rd2", i), b_rd2, vecs[i].exp_b2);
            tick();
        end
        idle();

        // clear_req with a simultaneous write: write dropped, no bypass
        clear_req = 1'b1;
        we1 = 1'b1; wr1 = 5'd8; wd1 = 32'hAAAA5555;
        rr1 = 5'd8; rr2 = 5'd7;
        #1;
        chk("clrreq_bypass_a", a_rd1, 32'h0);
        chk("clrreq_reg7_a", a_rd2, 32'h12345678);
        tick();
        idle();
        for (int k = 1; k <= 32; k++) begin
            if (k < 32) begin
                chk($sformatf("clrreq_ready_a_e%0d", k - 1), {31'd0, a_ready}, 32'd0);
                chk($sformatf("clrreq_rd_a2_e%0d", k - 1), a_rd2, 32'h0);
                chk($sformatf("clrreq_rd_b2_e%0d", k - 1), b_rd2, 32'h0);
            end
            tick();
        end
        chk("clrreq_done_ready_a", {31'd0, a_ready}, 32'd1);
        chk("clrreq_done_ready_b", {31'd0, b_ready}, 32'd1);
        chk("clrreq_reg8_a", a_rd1, 32'h0);
        chk("clrreq_reg7_a", a_rd2, 32'h0);
        chk("clrreq_reg8_b", b_rd1, 32'h0);
        chk("clrreq_reg7_b", b_rd2, 32'h0);
        rr1 = 5'd31; rr2 = 5'd0;
        #1;
        chk("clrreq_reg31_b", b_rd1, 32'h0);
        chk("clrreq_reg0_b", b_rd2, 32'h0);

        // Reset mid-scrub at clear_ptr=10 restarts the full count
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        chk("midscrub_ready_a", {31'd0, a_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 22 || k == 31) begin
                chk($sformatf("restart_ready_a_e%0d", k), {31'd0, a_ready}, 32'd0);
                chk($sformatf("restart_ready_b_e%0d", k), {31'd0, b_ready}, 32'd0);
            end
        end
        chk("restart_ready_a_e32", {31'd0, a_ready}, 32'd1);
        chk("restart_ready_b_e32", {31'd0, b_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
